// File: rtl/serial_to_array_packer.sv
// Serial-to-parallel packer: gathers M serial bits into a word and presents it both as a
// packed vector and as an unpacked array, with an assembler stage backed by an output register.
module serial_to_array_packer #(
    parameter int unsigned M         = 2,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                     clock,
    input  logic                     rstn,
    input  logic                     din,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic                     flush,
    output logic [M-1:0]             word_packed,
    output logic                     word_unpacked [0:M-1],
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [$clog2(M+1)-1:0]   bit_count
);

    localparam int unsigned CW = $clog2(M + 1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    localparam logic [CW-1:0] FULL_COUNT = CW'(M);
    localparam logic [CW-1:0] LAST_COUNT = CW'(M - 1);

    logic [0:0]    state_q, state_d;
    logic [M-1:0]  asm_q, asm_d;
    logic [CW-1:0] count_q, count_d;
    logic [M-1:0]  word_q, word_d;
    logic          valid_q, valid_d;

    logic [M-1:0]  asm_with_bit;
    int unsigned   bit_index;
    logic          out_free;

    // Past-the-end index while FULL simply matches no position.
    assign bit_index = MSB_FIRST ? (M - 1 - 32'(count_q)) : 32'(count_q);

    always_comb begin
        asm_with_bit = asm_q;
        for (int unsigned i = 0; i < M; i++) begin
            if (i == bit_index) begin
                asm_with_bit[i] = din;
            end
        end
    end

    assign out_free = !valid_q || word_ready;

    always_comb begin
        state_d = state_q;
        asm_d   = asm_q;
        count_d = count_q;
        word_d  = word_q;
        valid_d = valid_q && !word_ready;

        if (flush) begin
            // Discards partial or waiting word only; the output register is untouched.
            asm_d   = '0;
            count_d = '0;
            state_d = ST_FILL;
        end else if (state_q == ST_FULL) begin
            if (out_free) begin
                word_d  = asm_q;
                valid_d = 1'b1;
                asm_d   = '0;
                count_d = '0;
                state_d = ST_FILL;
            end
        end else if (din_valid) begin
            if (count_q == LAST_COUNT) begin
                if (out_free) begin
                    word_d  = asm_with_bit;
                    valid_d = 1'b1;
                    asm_d   = '0;
                    count_d = '0;
                end else begin
                    asm_d   = asm_with_bit;
                    count_d = FULL_COUNT;
                    state_d = ST_FULL;
                end
            end else begin
                asm_d   = asm_with_bit;
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_FILL;
            asm_q   <= '0;
            count_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            count_q <= count_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign din_ready   = (state_q == ST_FILL);
    assign word_packed = word_q;
    assign word_valid  = valid_q;
    assign bit_count   = count_q;

    always_comb begin
        for (int unsigned i = 0; i < M; i++) begin
            word_unpacked[i] = word_q[i];
        end
    end

endmodule

// File: tb/tb_serial_to_array_packer.sv
// Bench for serial_to_array_packer: five instances with different M / bit order share one
// stimulus stream and are checked every cycle against a word-queue model.
module tb_serial_to_array_packer;

    localparam int NI = 5;

    function automatic int unsigned m_of(input int k);
        case (k)
            0, 1:    return 4;
            2:       return 1;
            3:       return 2;
            default: return 7;
        endcase
    endfunction

    function automatic bit msb_of(input int k);
        return (k == 1) || (k == 4);
    endfunction

    logic clock;
    logic rstn;
    logic din;
    logic din_valid;
    logic flush;
    logic word_ready;

    logic        dr [NI];
    logic        wv [NI];
    logic [63:0] wp [NI];
    logic [63:0] ua [NI];
    logic [7:0]  bc [NI];

    for (genvar g = 0; g < NI; g++) begin : gen_dut
        localparam int unsigned MG   = m_of(g);
        localparam bit          MSBG = msb_of(g);

        logic [MG-1:0]             wpk;
        logic                      wuk [0:MG-1];
        logic [$clog2(MG+1)-1:0]   bck;
        logic [63:0]               uv;

        serial_to_array_packer #(
            .M         (MG),
            .MSB_FIRST (MSBG)
        ) u_dut (
            .clock         (clock),
            .rstn          (rstn),
            .din           (din),
            .din_valid     (din_valid),
            .din_ready     (dr[g]),
            .flush         (flush),
            .word_packed   (wpk),
            .word_unpacked (wuk),
            .word_valid    (wv[g]),
            .word_ready    (word_ready),
            .bit_count     (bck)
        );

        always_comb begin
            uv = '0;
            for (int i = 0; i < int'(MG); i++) uv[i] = wuk[i];
        end

        assign wp[g] = 64'(wpk);
        assign ua[g] = uv;
        assign bc[g] = 8'(bck);
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_on  = 1'b0;

    task automatic check(input string nm, input int k, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d t=%0t got=%0h expected=%0h", nm, k, $time, got, exp);
        end
    endtask

    // Model: undelivered complete words (0..2, head is the output word) plus the partial word.
    typedef struct packed {
        logic [1:0]  c;
        logic [6:0]  n;
        logic [63:0] p;
        logic [63:0] w0;
        logic [63:0] w1;
    } mstate_t;

    mstate_t ms [NI];

    function automatic mstate_t model_step(input mstate_t s, input int k);
        mstate_t     r;
        int unsigned m;
        int unsigned idx;
        r = s;
        m = m_of(k);
        if (s.c != 0 && word_ready) begin
            r.w0 = s.w1;
            r.c  = r.c - 2'd1;
        end
        if (flush) begin
            if (s.c == 2) r.c = r.c - 2'd1;
            r.n = '0;
            r.p = '0;
        end else if (din_valid && s.c != 2) begin
            idx = msb_of(k) ? (m - 1 - 32'(s.n)) : 32'(s.n);
            r.p = r.p | (64'(din) << idx);
            r.n = r.n + 7'd1;
            if (32'(r.n) == m) begin
                if (r.c == 0) r.w0 = r.p;
                else          r.w1 = r.p;
                r.c = r.c + 2'd1;
                r.n = '0;
                r.p = '0;
            end
        end
        return r;
    endfunction

    always @(posedge clock or negedge rstn) begin
        for (int k = 0; k < NI; k++) begin
            if (!rstn) ms[k] <= '0;
            else       ms[k] <= model_step(ms[k], k);
        end
    end

    always @(negedge clock) begin
        if (rstn && cmp_on) begin
            for (int k = 0; k < NI; k++) begin
                check("word_valid", k, 64'(wv[k]), 64'(ms[k].c != 0));
                check("din_ready", k, 64'(dr[k]), 64'(ms[k].c != 2));
                check("bit_count", k, 64'(bc[k]),
                      (ms[k].c == 2) ? 64'(m_of(k)) : 64'(ms[k].n));
                if (ms[k].c != 0) check("word", k, wp[k], ms[k].w0);
                check("unpacked_eq_packed", k, ua[k], wp[k]);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic b);
        din       = b;
        din_valid = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        rstn       = 1'b0;
        din        = 1'b0;
        din_valid  = 1'b0;
        flush      = 1'b0;
        word_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        do_reset();
        cmp_on = 1'b1;
        check("rst_valid", 0, 64'(wv[0]), 64'd0);
        check("rst_word", 0, wp[0], 64'd0);
        check("rst_unpacked", 0, ua[0], 64'd0);
        check("rst_count", 0, 64'(bc[0]), 64'd0);
        check("rst_din_ready", 0, 64'(dr[0]), 64'd1);

        // 1/2: stream 1,0,1,1 with consumer ready
        word_ready = 1'b1;
        send(1'b1); send(1'b0); send(1'b1);
        check("t1_not_yet", 0, 64'(wv[0]), 64'd0);
        send(1'b1);
        din_valid = 1'b0;
        check("t1_valid", 0, 64'(wv[0]), 64'd1);
        check("t1_packed", 0, wp[0], 64'hD);
        check("t1_unpacked", 0, ua[0], 64'hD);
        check("t2_packed_msb", 1, wp[1], 64'hB);
        check("t2_unpacked_msb", 1, ua[1], 64'hB);
        tick();
        check("t1_one_cycle", 0, 64'(wv[0]), 64'd0);

        // 3: backpressure, eight bits back-to-back
        do_reset();
        send(1'b1); send(1'b1); send(1'b0); send(1'b0);
        send(1'b0);
        check("t3_held_valid", 0, 64'(wv[0]), 64'd1);
        check("t3_held_word", 0, wp[0], 64'h3);
        send(1'b1); send(1'b0); send(1'b1);
        din_valid = 1'b0;
        check("t3_full_ready", 0, 64'(dr[0]), 64'd0);
        check("t3_full_count", 0, 64'(bc[0]), 64'd4);
        check("t3_still_word1", 0, wp[0], 64'h3);
        word_ready = 1'b1;
        tick();
        check("t3_no_bubble", 0, 64'(wv[0]), 64'd1);
        check("t3_word2", 0, wp[0], 64'hA);
        tick();
        check("t3_drained", 0, 64'(wv[0]), 64'd0);

        // 4: flush with a same-cycle valid bit
        do_reset();
        word_ready = 1'b1;
        send(1'b1); send(1'b1);
        flush = 1'b1;
        send(1'b1);
        flush = 1'b0;
        check("t4_count_cleared", 0, 64'(bc[0]), 64'd0);
        check("t4_no_word", 0, 64'(wv[0]), 64'd0);
        send(1'b0); send(1'b1); send(1'b1);
        check("t4_partial", 0, 64'(bc[0]), 64'd3);
        send(1'b0);
        din_valid = 1'b0;
        check("t4_valid", 0, 64'(wv[0]), 64'd1);
        check("t4_word", 0, wp[0], 64'h6);

        // 5: asynchronous reset while FULL
        do_reset();
        send(1'b1); send(1'b0); send(1'b0); send(1'b0);
        send(1'b1); send(1'b1); send(1'b1); send(1'b1);
        din_valid = 1'b0;
        check("t5_full", 0, 64'(dr[0]), 64'd0);
        #2 rstn = 1'b0;
        #1;
        check("t5_async_valid", 0, 64'(wv[0]), 64'd0);
        check("t5_async_word", 0, wp[0], 64'd0);
        check("t5_async_unpacked", 0, ua[0], 64'd0);
        check("t5_async_count", 0, 64'(bc[0]), 64'd0);
        #2 rstn = 1'b1;
        tick();
        check("t5_ready_after", 0, 64'(dr[0]), 64'd1);
        word_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_stale", 0, 64'(wv[0]), 64'd0);
        end

        // 6: random traffic, checked by the per-cycle model compare
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            din        = 1'($urandom_range(0, 1));
            din_valid  = ($urandom_range(0, 3) != 0);
            word_ready = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 63) == 0);
            tick();
        end
        din_valid = 1'b0;
        flush     = 1'b0;
        word_ready = 1'b1;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
